// File: rtl/nway_cache_pkg.sv
// rtl/nway_cache_pkg.sv - shared types and geometry helpers for the n-way cache
package nway_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } cache_state_e;

   localparam int OFFSET_BITS = 5;
   localparam int LINE_BITS   = 256;

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int sets);
      return 32 - OFFSET_BITS - $clog2(sets);
   endfunction

endpackage

// File: rtl/nway_cache_plru_tree.sv
// rtl/nway_cache_plru_tree.sv - tree pseudo-LRU update and victim selection
module plru_tree #(
   parameter int WAYS = 4,
   parameter int WB   = $clog2(WAYS)
) (
   input  logic [WAYS-2:0] bits,
   input  logic [WB-1:0]   hit_way,
   output logic [WAYS-2:0] next_bits,
   output logic [WB-1:0]   victim
);

   localparam int PW = WAYS - 1;

   // Heap-ordered nodes, node n stored at bit n-1; a 0 bit steers the victim left.
   always_comb begin : update
      int              node;
      logic [WB-1:0]   hw_sh;
      logic [WAYS-2:0] one_hot;
      next_bits = bits;
      node      = 1;
      for (int l = 0; l < WB; l++) begin
         hw_sh   = hit_way >> (WB - 1 - l);
         one_hot = PW'(1) << (node - 1);
         if (hw_sh[0]) next_bits = next_bits & ~one_hot;
         else          next_bits = next_bits | one_hot;
         node = 2 * node + int'(hw_sh[0]);
      end
   end

   always_comb begin : select
      int              node;
      logic [WAYS-2:0] b_sh;
      node = 1;
      for (int l = 0; l < WB; l++) begin
         b_sh = bits >> (node - 1);
         node = 2 * node + int'(b_sh[0]);
      end
      victim = WB'(node - WAYS);
   end

endmodule

// File: rtl/nway_cache.sv
// rtl/nway_cache.sv - N-way set-associative write-back write-allocate cache
module nway_cache
   import nway_cache_pkg::*;
#(
   parameter int WAYS = 4,
   parameter int SETS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  mem_address,
   input  logic [31:0]  mem_wdata,
   input  logic [3:0]   mem_byte_enable,
   output logic         mem_resp,
   output logic [31:0]  mem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int IDX  = index_bits(SETS);
   localparam int TAGW = tag_bits(SETS);
   localparam int WB   = $clog2(WAYS);

   cache_state_e state_q, state_d;

   logic [LINE_BITS-1:0]       data_q [WAYS][SETS];
   logic [TAGW-1:0]            tag_q  [WAYS][SETS];
   logic [SETS-1:0][WAYS-1:0]  valid_q, dirty_q;
   logic [SETS-1:0][WAYS-2:0]  plru_q;

   logic [IDX-1:0]       idx;
   logic [TAGW-1:0]      tag;
   logic [2:0]           word_sel;
   logic [WAYS-1:0]      set_valid, set_dirty, hit_vec, hv_sh, iv_sh;
   logic [WB-1:0]        hit_way, first_inv, plru_victim, victim_sel, victim_q;
   logic [WAYS-2:0]      plru_next;
   logic                 hit, any_inv, req, fill;
   logic [LINE_BITS-1:0] hit_line, write_line;
   logic [31:0]          byte_mask;
   logic                 unused_bits;

   assign idx         = mem_address[OFFSET_BITS +: IDX];
   assign tag         = mem_address[31 -: TAGW];
   assign word_sel    = mem_address[4:2];
   assign unused_bits = ^mem_address[1:0];
   assign set_valid   = valid_q[idx];
   assign set_dirty   = dirty_q[idx];
   assign req         = mem_read | mem_write;
   assign fill        = (state_q == ALLOCATE) && pmem_resp;

   for (genvar g = 0; g < WAYS; g++) begin : g_hit
      assign hit_vec[g] = set_valid[g] && (tag_q[g][idx] == tag);
   end

   // Descending scan so the lowest-numbered match wins.
   always_comb begin
      hit_way   = '0;
      first_inv = '0;
      any_inv   = 1'b0;
      hv_sh     = '0;
      iv_sh     = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hv_sh = hit_vec >> w;
         iv_sh = ~set_valid >> w;
         if (hv_sh[0]) hit_way = WB'(w);
         if (iv_sh[0]) begin
            first_inv = WB'(w);
            any_inv   = 1'b1;
         end
      end
   end

   assign hit        = |hit_vec;
   assign victim_sel = any_inv ? first_inv : plru_victim;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits      (plru_q[idx]),
      .hit_way   (hit_way),
      .next_bits (plru_next),
      .victim    (plru_victim)
   );

   assign hit_line  = data_q[hit_way][idx];
   assign mem_rdata = hit_line[{word_sel, 5'b0} +: 32];
   assign byte_mask = {{8{mem_byte_enable[3]}}, {8{mem_byte_enable[2]}},
                       {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};

   always_comb begin
      write_line = hit_line;
      write_line[{word_sel, 5'b0} +: 32] =
         (hit_line[{word_sel, 5'b0} +: 32] & ~byte_mask) | (mem_wdata & byte_mask);
   end

   always_comb begin
      state_d      = state_q;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = {mem_address[31:5], 5'b0};
      pmem_wdata   = data_q[victim_q][idx];
      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit)
                  mem_resp = 1'b1;
               else if (set_valid[victim_sel] && set_dirty[victim_sel])
                  state_d = WRITEBACK;
               else
                  state_d = ALLOCATE;
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[victim_q][idx], idx, 5'b0};
            if (pmem_resp) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            pmem_read = 1'b1;
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         plru_q  <= '0;
      end else begin
         state_q <= state_d;
         // Victim is frozen on leaving IDLE so the whole miss targets one way.
         if (state_q == IDLE) victim_q <= victim_sel;
         if (fill) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
         if (mem_resp) begin
            plru_q[idx] <= plru_next;
            if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (fill) begin
            data_q[victim_q][idx] <= pmem_rdata;
            tag_q[victim_q][idx]  <= tag;
         end else if (mem_resp && mem_write) begin
            data_q[hit_way][idx] <= write_line;
         end
      end
   end

endmodule
